// File: rtl/cursor_overlay_pkg.sv
// ============================================================================
// Module  : cursor_overlay_pkg
// Brief   : Shared pixel codes, state encoding and geometry for the cursor overlay.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cursor_overlay_pkg;

    localparam logic [1:0] PIX_CLEAR  = 2'b00;
    localparam logic [1:0] PIX_COLOR0 = 2'b01;
    localparam logic [1:0] PIX_COLOR1 = 2'b10;
    localparam logic [1:0] PIX_INVERT = 2'b11;

    localparam int H_ACTIVE    = 800;
    localparam int V_ACTIVE    = 600;
    localparam int CURSOR_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cursor_bitmap.sv
// ============================================================================
// Module  : cursor_bitmap
// Brief   : 16 x 32-bit cursor bitmap, one write port and one combinational read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cursor_bitmap
    import cursor_overlay_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  wr_row,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_row,
    output logic [31:0] rd_data
);

    logic [31:0] r_rows [CURSOR_SIZE];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CURSOR_SIZE; i++) begin
                r_rows[i] <= '0;
            end
        end else if (we) begin
            r_rows[wr_row] <= wr_data;
        end
    end

    // Read sees pre-write contents, so a same-cycle write is not visible yet.
    assign rd_data = r_rows[rd_row];

endmodule

`default_nettype wire

// File: rtl/cursor_overlay.sv
// ============================================================================
// Module  : cursor_overlay
// Brief   : Composites a 16x16 2-bit-per-pixel hardware cursor over background video.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cursor_overlay
    import cursor_overlay_pkg::*;
#(
    parameter logic [11:0] COLOR0 = 12'h000,
    parameter logic [11:0] COLOR1 = 12'hFFF
) (
    input  logic        clk40,
    input  logic        rst_n,
    input  logic        videoActive,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        lineStarting,
    input  logic        lineEnding,
    input  logic [9:0]  hPos,
    input  logic [9:0]  vPos,
    input  logic [3:0]  bg_red,
    input  logic [3:0]  bg_green,
    input  logic [3:0]  bg_blue,
    input  logic [9:0]  cursor_x,
    input  logic [9:0]  cursor_y,
    input  logic        cursor_en,
    input  logic        bmp_we,
    input  logic [3:0]  bmp_row,
    input  logic [31:0] bmp_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        videoActive_out
);

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_vsync_d;
    logic [9:0]  r_cur_x;
    logic [9:0]  r_cur_y;
    logic        r_cur_en;
    logic [31:0] r_shift;
    logic [31:0] w_shift_nx;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nx;
    logic        w_draw;
    logic        w_start;
    logic        w_hit;
    logic [10:0] w_row_off;
    logic [31:0] w_row_data;
    logic [11:0] w_bg;
    logic [11:0] w_pix;

    cursor_bitmap u_bitmap (
        .clk     (clk40),
        .rst_n   (rst_n),
        .we      (bmp_we),
        .wr_row  (bmp_row),
        .wr_data (bmp_data),
        .rd_row  (w_row_off[3:0]),
        .rd_data (w_row_data)
    );

    // 11-bit difference: lines above cur_y wrap to large values and miss.
    assign w_row_off = {1'b0, vPos} - {1'b0, r_cur_y};
    assign w_hit     = r_cur_en && (w_row_off[10:4] == 7'd0) && (vPos < 10'(V_ACTIVE));
    assign w_start   = videoActive && (hPos == r_cur_x) && (r_cur_x < 10'(H_ACTIVE));

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_count_nx = r_count;
        w_draw     = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (w_start) begin
                    w_draw     = 1'b1;
                    w_shift_nx = r_shift << 2;
                    w_count_nx = 4'd1;
                    w_state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_draw     = 1'b1;
                w_shift_nx = r_shift << 2;
                w_count_nx = r_count + 4'd1;
                if (r_count == 4'(CURSOR_SIZE - 1)) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (lineStarting) begin
            w_state_nx = w_hit ? ST_ARMED : ST_IDLE;
            w_shift_nx = w_row_data;
            w_count_nx = '0;
        end else if (lineEnding) begin
            w_state_nx = ST_IDLE;
        end
    end

    assign w_bg = {bg_red, bg_green, bg_blue};

    always_comb begin
        w_pix = w_bg;
        if (w_draw) begin
            case (r_shift[31:30])
                PIX_COLOR0: w_pix = COLOR0;
                PIX_COLOR1: w_pix = COLOR1;
                PIX_INVERT: w_pix = ~w_bg;
                default:    w_pix = w_bg;
            endcase
        end
    end

    always_ff @(posedge clk40) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_count   <= '0;
            r_vsync_d <= 1'b0;
            r_cur_x   <= '0;
            r_cur_y   <= '0;
            r_cur_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_count   <= w_count_nx;
            r_vsync_d <= vsync;
            if (vsync && !r_vsync_d) begin
                r_cur_x  <= cursor_x;
                r_cur_y  <= cursor_y;
                r_cur_en <= cursor_en;
            end
        end
    end

    always_ff @(posedge clk40) begin
        if (!rst_n) begin
            {red, green, blue} <= '0;
            hsync_out          <= 1'b0;
            vsync_out          <= 1'b0;
            videoActive_out    <= 1'b0;
        end else begin
            hsync_out       <= hsync;
            vsync_out       <= vsync;
            videoActive_out <= videoActive;
            if (!videoActive) begin
                {red, green, blue} <= '0;
            end else begin
                {red, green, blue} <= w_pix;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cursor_overlay.sv
// ============================================================================
// Module  : tb_cursor_overlay
// Brief   : Directed bench for cursor_overlay with a geometric reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cursor_overlay;
    import cursor_overlay_pkg::*;

    localparam logic [11:0] C_COLOR0 = 12'h123;
    localparam logic [11:0] C_COLOR1 = 12'hEDB;

    logic        clk40 = 1'b0;
    logic        rst_n, videoActive, hsync, vsync, lineStarting, lineEnding;
    logic [9:0]  hPos, vPos, cursor_x, cursor_y;
    logic [3:0]  bg_red, bg_green, bg_blue, bmp_row;
    logic        cursor_en, bmp_we;
    logic [31:0] bmp_data;
    logic [3:0]  red, green, blue;
    logic        hsync_out, vsync_out, videoActive_out;

    always #5 clk40 = ~clk40;

    cursor_overlay #(.COLOR0(C_COLOR0), .COLOR1(C_COLOR1)) dut (
        .clk40(clk40), .rst_n(rst_n), .videoActive(videoActive), .hsync(hsync),
        .vsync(vsync), .lineStarting(lineStarting), .lineEnding(lineEnding),
        .hPos(hPos), .vPos(vPos), .bg_red(bg_red), .bg_green(bg_green),
        .bg_blue(bg_blue), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cursor_en(cursor_en), .bmp_we(bmp_we), .bmp_row(bmp_row),
        .bmp_data(bmp_data), .red(red), .green(green), .blue(blue),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .videoActive_out(videoActive_out)
    );

    // Reference model: latched cursor, bitmap copy, per-line snapshot.
    logic [31:0] m_bmp [16];
    logic [9:0]  m_cx, m_cy;
    logic        m_cen, m_vs_prev, m_hit;
    logic [31:0] m_snap;
    logic [14:0] exp_q [$];
    int          n_pass  = 0;
    int          n_total = 0;
    string       tag;
    bit          fixed_bg = 1'b0;
    int          rst_at   = -1;

    function automatic logic [11:0] pix(input logic [1:0] code, input logic [11:0] bg);
        case (code)
            2'b01:   return C_COLOR0;
            2'b10:   return C_COLOR1;
            2'b11:   return ~bg;
            default: return bg;
        endcase
    endfunction

    task automatic step();
        logic [11:0] rgb;
        logic [14:0] e, o;
        int          off, d;
        if (!rst_n) begin
            e = '0;
            m_cen = 1'b0; m_cx = '0; m_cy = '0; m_vs_prev = 1'b0; m_hit = 1'b0;
            for (int i = 0; i < 16; i++) m_bmp[i] = '0;
        end else begin
            rgb = {bg_red, bg_green, bg_blue};
            off = int'(hPos) - int'(m_cx);
            if (!videoActive)
                rgb = '0;
            else if (m_hit && off >= 0 && off < 16)
                rgb = pix(2'((m_snap >> (30 - 2 * off)) & 32'd3), rgb);
            e = {rgb, hsync, vsync, videoActive};
            if (lineStarting) begin
                d = int'(vPos) - int'(m_cy);
                m_hit = m_cen && d >= 0 && d < 16 && vPos < 10'd600;
                if (m_hit) m_snap = m_bmp[d];
            end else if (lineEnding) begin
                m_hit = 1'b0;
            end
            if (vsync && !m_vs_prev) begin
                m_cx = cursor_x; m_cy = cursor_y; m_cen = cursor_en;
            end
            m_vs_prev = vsync;
            if (bmp_we) m_bmp[bmp_row] = bmp_data;
        end
        exp_q.push_back(e);
        @(posedge clk40);
        #1;
        e = exp_q.pop_front();
        o = {red, green, blue, hsync_out, vsync_out, videoActive_out};
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s h=%0d v=%0d rst_n=%0b observed=%h expected=%h",
                    tag, hPos, vPos, rst_n, o, e);
    endtask

    task automatic vsync_pulse();
        videoActive = 1'b0;
        vsync = 1'b1; step(); step();
        vsync = 1'b0; step();
    endtask

    task automatic line(input int v, input int h0, input int h1);
        vPos = 10'(v); hPos = 10'(h0 - 1); videoActive = 1'b0; lineStarting = 1'b1;
        step();
        lineStarting = 1'b0; bmp_we = 1'b0;
        for (int h = h0; h <= h1; h++) begin
            hPos        = 10'(h);
            videoActive = (h < 800) && (v < 600);
            if (fixed_bg) {bg_red, bg_green, bg_blue} = 12'hA53;
            else          {bg_red, bg_green, bg_blue} = {4'(h), 4'(h >> 4), 4'(v)};
            rst_n = (h != rst_at);
            step();
        end
        rst_n = 1'b1; videoActive = 1'b0; lineEnding = 1'b1; hsync = 1'b1;
        step();
        lineEnding = 1'b0; hsync = 1'b0;
    endtask

    task automatic load_all(input logic [31:0] pat);
        for (int r = 0; r < 16; r++) begin
            bmp_we = 1'b1; bmp_row = 4'(r); bmp_data = pat;
            step();
        end
        bmp_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; videoActive = 1'b0; hsync = 1'b0; vsync = 1'b0;
        lineStarting = 1'b0; lineEnding = 1'b0; hPos = '0; vPos = '0;
        {bg_red, bg_green, bg_blue} = 12'h7C4;
        cursor_x = '0; cursor_y = '0; cursor_en = 1'b0;
        bmp_we = 1'b0; bmp_row = '0; bmp_data = '0;

        tag = "reset";
        repeat (3) step();
        rst_n = 1'b1;

        tag = "color0_block";
        load_all(32'h5555_5555);
        cursor_x = 10'd100; cursor_y = 10'd50; cursor_en = 1'b1;
        vsync_pulse();
        line(49, 95, 120); line(50, 95, 120); line(65, 95, 120); line(66, 95, 120);

        tag = "invert_pixel";
        bmp_we = 1'b1; bmp_row = 4'd0; bmp_data = 32'hC000_0000; step(); bmp_we = 1'b0;
        vsync_pulse();
        fixed_bg = 1'b1; line(50, 98, 118); fixed_bg = 1'b0;

        tag = "bottom_clip";
        load_all(32'hAAAA_AAAA);
        cursor_y = 10'd590;
        vsync_pulse();
        for (int v = 588; v <= 605; v++) line(v, 98, 118);
        tag = "no_top_wrap";
        vsync_pulse();
        for (int v = 0; v <= 5; v++) line(v, 98, 118);

        tag = "right_clip";
        cursor_x = 10'd790; cursor_y = 10'd50;
        vsync_pulse();
        line(50, 785, 805);
        tag = "offscreen_x";
        cursor_x = 10'd900;
        vsync_pulse();
        line(50, 785, 805);
        n_total++;
        assert (dut.r_state === ST_IDLE) n_pass++;
        else $error("FAIL offscreen_state observed=%0d expected=%0d", dut.r_state, ST_IDLE);

        tag = "midframe_move";
        cursor_x = 10'd100;
        vsync_pulse();
        line(50, 95, 220);
        cursor_x = 10'd200;
        line(51, 95, 220);
        vsync_pulse();
        line(50, 95, 220);

        tag = "snapshot";
        cursor_x = 10'd100;
        bmp_we = 1'b1; bmp_row = 4'd3; bmp_data = 32'h5555_5555; step(); bmp_we = 1'b0;
        vsync_pulse();
        bmp_we = 1'b1; bmp_row = 4'd3; bmp_data = 32'hFFFF_0000;
        line(53, 95, 120);
        vsync_pulse();
        line(53, 95, 120);

        tag = "reset_in_shift";
        rst_at = 105;
        line(53, 95, 120);
        rst_at = -1;
        line(53, 95, 120);
        tag = "resume_after_latch";
        bmp_we = 1'b1; bmp_row = 4'd3; bmp_data = 32'h9C39_C3A5; step(); bmp_we = 1'b0;
        vsync_pulse();
        line(53, 95, 120);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
